// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - active-low common-anode 7-segment patterns {dp,g,f,e,d,c,b,a} and BCD decode.
package seg7_pkg;

  localparam logic [7:0] SEG7_BLANK = 8'hFF;

  localparam logic [7:0] SEG7_DIGIT [0:9] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
    8'h92, 8'h82, 8'hD8, 8'h80, 8'h90
  };

  function automatic logic [7:0] seg7_decode(input logic [3:0] bcd);
    if (bcd > 4'd9) return SEG7_BLANK;
    return SEG7_DIGIT[bcd];
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - one BCD decade register with load/clear/inc/dec and ripple carry/borrow.
module bcd_digit (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_digit,
  input  logic       clear,
  input  logic       inc,
  input  logic       dec,
  input  logic       cin,
  input  logic       bin,
  output logic [3:0] digit,
  output logic       cout,
  output logic       bout
);

  // carry/borrow ripple depends only on stored digits, never on inc/dec
  assign cout = cin & (digit == 4'd9);
  assign bout = bin & (digit == 4'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      digit <= 4'd0;
    end else if (load) begin
      digit <= (load_digit > 4'd9) ? 4'd9 : load_digit;
    end else if (clear) begin
      digit <= 4'd0;
    end else if (inc && cin) begin
      digit <= (digit == 4'd9) ? 4'd0 : digit + 4'd1;
    end else if (dec && bin) begin
      digit <= (digit == 4'd0) ? 4'd9 : digit - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_updown_display.sv
// rtl/bcd_updown_display.sv - DIGITS-decade BCD up/down counter with multiplexed 7-segment scan.
// Define BCD_LZ_BLANK_EN to blank leading zeros on the display.
module bcd_updown_display
  import seg7_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 12000,
  parameter int SCAN_DIV = 48,
  parameter int SATURATE = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  up_n,
  input  logic                  down_n,
  input  logic                  clear_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  output logic [4*DIGITS-1:0]   count_bcd,
  output logic                  wrap,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     digit_en_n
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);
  localparam bit            SAT       = (SATURATE != 0);

  logic [TW-1:0] tdiv;
  logic [SW-1:0] sdiv;
  logic [IW-1:0] scan_idx;
  logic          tick;
  logic          do_clear, do_up, do_dn, inc, dec, wrap_d;
  logic [DIGITS:0] carry, borrow;
  logic [3:0]    digit_q [DIGITS];
  logic [3:0]    cur_digit;
  logic          blank;
  logic [7:0]    seg_d;
  logic [DIGITS-1:0] en_onehot;

  assign tick     = (tdiv == TICK_LAST);
  assign do_clear = tick & ~clear_n;
  assign do_up    = tick & clear_n & ~up_n;
  assign do_dn    = tick & clear_n & up_n & ~down_n;

  // carry[DIGITS]/borrow[DIGITS] flag the all-9 / all-0 roll points
  assign inc    = do_up & ~(SAT & carry[DIGITS]);
  assign dec    = do_dn & ~(SAT & borrow[DIGITS]);
  assign wrap_d = ~load & ~SAT & ((do_up & carry[DIGITS]) | (do_dn & borrow[DIGITS]));

  assign carry[0]  = 1'b1;
  assign borrow[0] = 1'b1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .clk        (clk),
      .rst        (rst),
      .load       (load),
      .load_digit (load_value[4*i +: 4]),
      .clear      (do_clear),
      .inc        (inc),
      .dec        (dec),
      .cin        (carry[i]),
      .bin        (borrow[i]),
      .digit      (digit_q[i]),
      .cout       (carry[i+1]),
      .bout       (borrow[i+1])
    );
    assign count_bcd[4*i +: 4] = digit_q[i];
  end

  assign cur_digit = digit_q[scan_idx];

`ifdef BCD_LZ_BLANK_EN
  logic [DIGITS:0] lz;

  // lz[i]: digit i and every digit above it are zero
  always_comb begin
    lz         = '0;
    lz[DIGITS] = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      lz[i] = lz[i+1] & (digit_q[i] == 4'd0);
    end
  end

  assign blank = (scan_idx != '0) && lz[scan_idx];
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    seg_d               = blank ? SEG7_BLANK : seg7_decode(cur_digit);
    en_onehot           = '0;
    en_onehot[scan_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tdiv       <= '0;
      sdiv       <= '0;
      scan_idx   <= '0;
      wrap       <= 1'b0;
      seg        <= SEG7_DIGIT[0];
      digit_en_n <= ~(DIGITS'(1));
    end else begin
      tdiv <= tick ? '0 : tdiv + 1'b1;
      wrap <= wrap_d;
      if (sdiv == SCAN_LAST) begin
        sdiv     <= '0;
        scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
      end else begin
        sdiv <= sdiv + 1'b1;
      end
      // both display outputs come from the same index on the same edge
      seg        <= seg_d;
      digit_en_n <= ~en_onehot;
    end
  end

endmodule

// File: tb/tb_bcd_updown_display.sv
// tb/tb_bcd_updown_display.sv - directed bench for bcd_updown_display, wrap and saturate builds side by side.
module tb_bcd_updown_display;

  logic        clk = 1'b0;
  logic        rst, up_n, down_n, clear_n, load;
  logic [15:0] load_value;
  logic [15:0] count0, count1;
  logic        wrap0, wrap1;
  logic [7:0]  seg0, seg1;
  logic [3:0]  en0, en1;

  int n_cmp  = 0;
  int n_err  = 0;
  int k      = 0;
  int wraps0 = 0;
  int wraps1 = 0;

  always #5 clk = ~clk;

  bcd_updown_display #(.DIGITS(4), .TICK_DIV(4), .SCAN_DIV(2), .SATURATE(0)) u_wrap (
    .clk(clk), .rst(rst), .up_n(up_n), .down_n(down_n), .clear_n(clear_n),
    .load(load), .load_value(load_value), .count_bcd(count0), .wrap(wrap0),
    .seg(seg0), .digit_en_n(en0)
  );

  bcd_updown_display #(.DIGITS(4), .TICK_DIV(4), .SCAN_DIV(2), .SATURATE(1)) u_sat (
    .clk(clk), .rst(rst), .up_n(up_n), .down_n(down_n), .clear_n(clear_n),
    .load(load), .load_value(load_value), .count_bcd(count1), .wrap(wrap1),
    .seg(seg1), .digit_en_n(en1)
  );

  always @(negedge clk) begin
    if (wrap0 === 1'b1) wraps0++;
    if (wrap1 === 1'b1) wraps1++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // k = number of edges since the last reset edge
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      k++;
    end
    #1;
  endtask

  logic [7:0] exp_seg;
  logic [3:0] exp_en;
  int         idx;

  initial begin
    rst = 1'b1; up_n = 1'b1; down_n = 1'b1; clear_n = 1'b1; load = 1'b0; load_value = '0;
    step(3);
    k = 0;
    rst = 1'b0;
    check("rst_count", count0, 32'h0000);
    check("rst_wrap", wrap0, 0);
    check("rst_seg", seg0, 32'hC0);
    check("rst_en", en0, 32'hE);

    // 12 up ticks
    up_n = 1'b0;
    step(4);
    check("up_first_tick", count0, 32'h0001);
    step(44);
    check("up12_count", count0, 32'h0012);
    check("up12_count_sat", count1, 32'h0012);
    check("up12_no_wrap", wraps0, 0);

    // roll over 9999 (k=48)
    load = 1'b1; load_value = 16'h9998;
    step(1);
    load = 1'b0;
    check("load9998", count0, 32'h9998);
    step(3);
    check("to9999", count0, 32'h9999);
    check("to9999_sat", count1, 32'h9999);
    step(4);
    check("wrap_count", count0, 32'h0000);
    check("wrap_pulse", wrap0, 1);
    check("sat_hold", count1, 32'h9999);
    check("sat_no_wrap", wrap1, 0);
    step(1);
    check("wrap_one_cycle", wrap0, 0);
    step(3);
    check("sat_hold2", count1, 32'h9999);
    check("wrap_total1", wraps0, 1);

    // roll under 0000 (k=60)
    up_n = 1'b1; load = 1'b1; load_value = 16'h0000;
    step(1);
    load = 1'b0; down_n = 1'b0;
    step(3);
    check("down_wrap_count", count0, 32'h9999);
    check("down_wrap_pulse", wrap0, 1);
    check("down_sat_hold", count1, 32'h0000);
    check("down_sat_no_wrap", wrap1, 0);
    step(1);

    // up beats down (k=65)
    up_n = 1'b0; load = 1'b1; load_value = 16'h0005;
    step(1);
    load = 1'b0;
    step(2);
    check("up_over_down", count0, 32'h0006);

    // clamp and load-vs-tick (k=68)
    load = 1'b1; load_value = 16'hA3F1;
    step(1);
    load = 1'b0;
    check("load_clamp", count0, 32'h9391);
    check("load_clamp_sat", count1, 32'h9391);
    step(2);
    load = 1'b1; load_value = 16'h1234;
    step(1);
    load = 1'b0; up_n = 1'b1; down_n = 1'b1;
    check("load_beats_tick", count0, 32'h1234);

    // display scan of 0042 (k=72)
    load = 1'b1; load_value = 16'h0042;
    step(1);
    load = 1'b0;
    for (int j = 0; j < 8; j++) begin
      step(1);
      idx = ((k - 1) / 2) % 4;
      case (idx)
        0: begin exp_en = 4'hE; exp_seg = 8'hA4; end
        1: begin exp_en = 4'hD; exp_seg = 8'h99; end
        2: exp_en = 4'hB;
        default: exp_en = 4'h7;
      endcase
`ifdef BCD_LZ_BLANK_EN
      if (idx >= 2) exp_seg = 8'hFF;
`else
      if (idx >= 2) exp_seg = 8'hC0;
`endif
      check($sformatf("scan_en_%0d", j), en0, exp_en);
      check($sformatf("scan_seg_%0d", j), seg0, exp_seg);
    end

    // reset over tick and load (k=81)
    load = 1'b1; load_value = 16'h0317;
    step(1);
    load = 1'b0; up_n = 1'b0;
    step(1);
    check("pre_rst", count0, 32'h0317);
    rst = 1'b1; load = 1'b1; load_value = 16'h5555;
    step(1);
    rst = 1'b0; load = 1'b0;
    k = 0;
    check("rst_mid_count", count0, 32'h0000);
    check("rst_mid_seg", seg0, 32'hC0);
    check("rst_mid_en", en0, 32'hE);
    check("rst_mid_wrap", wrap0, 0);
    step(4);
    check("post_rst_tick", count0, 32'h0001);

    // clear beats up
    clear_n = 1'b0;
    step(4);
    clear_n = 1'b1; up_n = 1'b1;
    check("clear", count0, 32'h0000);
    check("wrap_total_final", wraps0, 2);
    check("sat_wrap_total", wraps1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
